lcd_sync_gen: RTL
=================

Name: lcd_sync_gen

Overview:
- Parallel-RGB LCD timing generator. Produces HSYNC, VSYNC, DE, active-pixel coordinates and frame/line strobes.
- Sits directly upstream of the pixel/pattern stages (colour bar, text overlay, framebuffer reader). Those stages consume the coordinates and DE instead of keeping their own counters.
- Defaults target the 800x480 panel at the current porch settings.

Parameters:
- H_SYNC, 1, HSYNC width in pixel clocks
- H_BACK, 182, horizontal back porch (clocks after sync, before active)
- H_ACTIVE, 800, active pixels per line
- H_FRONT, 210, horizontal front porch
- V_SYNC, 5, VSYNC width in lines
- V_BACK, 0, vertical back porch in lines
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 45, vertical front porch in lines
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level (0 = active-low)
- X_W, 11, pixel_x width
- Y_W, 10, pixel_y width

Ports:
- PixelClk  in  1  pixel clock; sole clock
- nRST  in  1  asynchronous, active-low reset
- timing_en  in  1  run enable; low = hold in idle
- LCD_HSYNC  out  1  horizontal sync, polarity per HS_POL
- LCD_VSYNC  out  1  vertical sync, polarity per VS_POL
- LCD_DE  out  1  data enable, high during active pixels
- pixel_x  out  X_W  active column, 0..H_ACTIVE-1
- pixel_y  out  Y_W  active row, 0..V_ACTIVE-1
- line_start  out  1  one-clock pulse on first active pixel of each active line
- frame_start  out  1  one-clock pulse on pixel (0,0) of each frame

Behaviour:
- Clock and reset: one clock, PixelClk. Reset nRST is asynchronous and active-low.
- Totals:
  - H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (default 1193).
  - V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT (default 530).
  - Counter widths are sized with $clog2 of the totals.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments only on h_cnt wrap. It counts 0..V_TOTAL-1, then wraps to 0.
  - Both wraps are a single-cycle event, with no extra idle clock.
- Decode, registered:
  - HSYNC active when h_cnt < H_SYNC.
  - VSYNC active when v_cnt < V_SYNC.
  - h_act when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE.
  - v_act is defined the same way with the vertical parameters.
  - DE = h_act && v_act.
- Outputs: all outputs are registered with 1-clock latency from the counter state. All outputs are mutually aligned in the same cycle. No combinational path from PixelClk to any output.
- pixel_x / pixel_y:
  - pixel_x = h_cnt - (H_SYNC+H_BACK) and pixel_y = v_cnt - (V_SYNC+V_BACK) whenever DE=1.
  - Both are forced to 0 when DE=0.
  - Subtraction is done at counter width, then truncated to X_W/Y_W.
- line_start = DE && pixel_x==0. frame_start = line_start && pixel_y==0.
- Reset state:
  - h_cnt=0, v_cnt=0.
  - LCD_HSYNC = ~HS_POL and LCD_VSYNC = ~VS_POL (inactive).
  - LCD_DE=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0.
- timing_en:
  - Sampled each clock. When low, the counters are synchronously cleared to 0 and all outputs go to their reset values on the next clock.
  - When it returns high, counting resumes from h_cnt=0, v_cnt=0, so the first output frame is complete.
  - Deassertion mid-line or mid-frame aborts immediately. No partial-frame completion.
- Reset mid-frame: asynchronous clear to the reset state. Restart behaves as timing_en rising.
- Elaboration: H_ACTIVE and V_ACTIVE must be >= 1. H_SYNC and V_SYNC must be >= 1. Porches may be 0. Illegal values must fail elaboration via a generate-time check.

Optional Feature:
- Macro: LCD_SYNC_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [7:0], reset 0.
  - Increments, wrapping 255->0, in the same cycle frame_start is asserted, so frame_cnt reads the new value alongside frame_start.
  - Cleared when timing_en is low.
  - Used by animated test patterns.
- Undefined: port and logic absent; all other behaviour unchanged.

Test Plan:
- Reset/idle: hold nRST=0 with HS_POL=VS_POL=0 -> LCD_HSYNC=1, LCD_VSYNC=1, LCD_DE=0, pixel_x=pixel_y=0. Release with timing_en=0 -> outputs unchanged for 100 clocks.
- Small-geometry frame: H_SYNC=2, H_BACK=3, H_ACTIVE=4, H_FRONT=1, V_SYNC=1, V_BACK=1, V_ACTIVE=3, V_FRONT=2.
  - Expect 10 clocks per line and 7 lines per frame.
  - DE high for exactly 12 clocks per frame.
  - pixel_x sequence 0,1,2,3 on each active line; pixel_y 0,1,2.
- Strobes: same geometry over 3 frames -> frame_start pulses exactly every 70 clocks, coincident with DE=1, pixel_x=0, pixel_y=0. line_start pulses 3 times per frame.
- Default geometry: count clocks between HSYNC falling edges = 1193. Lines per VSYNC period = 530. DE-high clocks per frame = 384000.
- Abort: drop timing_en at pixel_x=2, pixel_y=1 -> next clock all outputs idle. Re-raise -> first DE after exactly H_SYNC+H_BACK + (V_SYNC+V_BACK)*H_TOTAL + 1 clocks, with frame_start asserted.
- LCD_SYNC_FRAME_CNT_EN: run 257 frames -> frame_cnt reads 1,2,...,255,0,1 at successive frame_start pulses.

Source files
------------

// File: rtl/lcd_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_sync_gen
// Purpose  : Parallel-RGB LCD timing generator. Free-running horizontal and
//            vertical counters are decoded into HSYNC, VSYNC, DE, the
//            active-pixel coordinates and line/frame start strobes. All
//            outputs are registered one clock after the counter state they
//            describe, so every output is aligned in the same cycle.
// Ports    : PixelClk    - pixel clock, sole clock
//            nRST        - asynchronous active-low reset
//            timing_en   - run enable; low clears counters, outputs idle
//            LCD_HSYNC   - horizontal sync, active level HS_POL
//            LCD_VSYNC   - vertical sync, active level VS_POL
//            LCD_DE      - data enable, high on active pixels
//            pixel_x     - active column (0 outside DE)
//            pixel_y     - active row (0 outside DE)
//            line_start  - pulse on first active pixel of each active line
//            frame_start - pulse on pixel (0,0) of each frame
//            frame_cnt   - frame counter, present only when
//                          LCD_SYNC_FRAME_CNT_EN is defined
// Macro    : LCD_SYNC_FRAME_CNT_EN adds the 8-bit frame_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_sync_gen #(
  parameter int   H_SYNC   = 1,
  parameter int   H_BACK   = 182,
  parameter int   H_ACTIVE = 800,
  parameter int   H_FRONT  = 210,
  parameter int   V_SYNC   = 5,
  parameter int   V_BACK   = 0,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 45,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   X_W      = 11,
  parameter int   Y_W      = 10
) (
  input  logic           PixelClk,
  input  logic           nRST,
  input  logic           timing_en,
  output logic           LCD_HSYNC,
  output logic           LCD_VSYNC,
  output logic           LCD_DE,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           line_start,
  output logic           frame_start
`ifdef LCD_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]     frame_cnt
`endif
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HC_W      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VC_W      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int H_ACT_BEG = H_SYNC + H_BACK;
  localparam int V_ACT_BEG = V_SYNC + V_BACK;

  // Window bounds can equal the total (zero front porch), so comparisons
  // are made one bit wider than the counters.
  localparam logic [HC_W:0]   H_SYNC_C = (HC_W+1)'(H_SYNC);
  localparam logic [HC_W:0]   H_BEG_C  = (HC_W+1)'(H_ACT_BEG);
  localparam logic [HC_W:0]   H_END_C  = (HC_W+1)'(H_ACT_BEG + H_ACTIVE);
  localparam logic [VC_W:0]   V_SYNC_C = (VC_W+1)'(V_SYNC);
  localparam logic [VC_W:0]   V_BEG_C  = (VC_W+1)'(V_ACT_BEG);
  localparam logic [VC_W:0]   V_END_C  = (VC_W+1)'(V_ACT_BEG + V_ACTIVE);
  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0] H_OFF    = HC_W'(H_ACT_BEG);
  localparam logic [VC_W-1:0] V_OFF    = VC_W'(V_ACT_BEG);

  generate
    if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1 ||
        H_BACK < 0 || H_FRONT < 0 || V_BACK < 0 || V_FRONT < 0) begin : g_bad_geometry
      $error("lcd_sync_gen: illegal timing geometry");
    end
  endgenerate

  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic            h_wrap;
  logic            v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!timing_en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Decode of the current counter state; registered below.
  logic [HC_W:0]   h_ext;
  logic [VC_W:0]   v_ext;
  logic            hs_act;
  logic            vs_act;
  logic            h_act;
  logic            v_act;
  logic            de_nxt;
  logic [HC_W-1:0] h_off;
  logic [VC_W-1:0] v_off;
  logic            ls_nxt;
  logic            fs_nxt;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign hs_act = (h_ext < H_SYNC_C);
  assign vs_act = (v_ext < V_SYNC_C);
  assign h_act  = (h_ext >= H_BEG_C) && (h_ext < H_END_C);
  assign v_act  = (v_ext >= V_BEG_C) && (v_ext < V_END_C);
  assign de_nxt = h_act && v_act;
  assign h_off  = h_cnt - H_OFF;
  assign v_off  = v_cnt - V_OFF;
  assign ls_nxt = de_nxt && (h_cnt == H_OFF);
  assign fs_nxt = ls_nxt && (v_cnt == V_OFF);

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_HSYNC   <= ~HS_POL;
      LCD_VSYNC   <= ~VS_POL;
      LCD_DE      <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!timing_en) begin
      LCD_HSYNC   <= ~HS_POL;
      LCD_VSYNC   <= ~VS_POL;
      LCD_DE      <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      LCD_HSYNC   <= hs_act ? HS_POL : ~HS_POL;
      LCD_VSYNC   <= vs_act ? VS_POL : ~VS_POL;
      LCD_DE      <= de_nxt;
      pixel_x     <= de_nxt ? X_W'(h_off) : '0;
      pixel_y     <= de_nxt ? Y_W'(v_off) : '0;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef LCD_SYNC_FRAME_CNT_EN
  // Advances on the same edge that raises frame_start, so the new count
  // is visible together with the strobe.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      frame_cnt <= 8'd0;
    end else if (!timing_en) begin
      frame_cnt <= 8'd0;
    end else if (fs_nxt) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire
